restoring_div_ctrl: RTL

- Sequential unsigned restoring divider: N-bit dividend by N-bit divisor, one quotient bit per clock, `start`/`done` handshake.
- Each cycle drives one (N+1)-bit trial-subtract/restore row built from the existing add/subtract-with-restore bit cell. The cell's `s` input complements `b`; its `s1` input selects pass-through of `a`.
- Sits between a requesting datapath and the divide array. Owns sequencing, operand registers and divide-by-zero handling.

---
 rtl/rdiv_pkg.sv | 15 +
 rtl/rdiv_cell.sv | 22 ++
 rtl/rdiv_row.sv | 33 +++
 rtl/restoring_div_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rdiv_pkg.sv
// Shared definitions for the sequential restoring divider: controller state
// encodings and the state enum used by restoring_div_ctrl.
package rdiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ITER = ST_ITER,
    DONE = ST_DONE
  } rdiv_state_t;

endpackage

// File: rtl/rdiv_cell.sv
// Add/subtract-with-restore bit cell: s complements b for subtraction,
// s1 passes a straight through to op (restore) instead of the sum.
module rdiv_cell (
  input  logic a,
  input  logic b,
  input  logic s,
  input  logic s1,
  input  logic cin,
  output logic op,
  output logic cout
);

  logic bx;
  logic sum;

  // Carry is taken from the arithmetic path only, so cout never depends on s1.
  assign bx   = b ^ s;
  assign sum  = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);
  assign op   = s1 ? a : sum;

endmodule

// File: rtl/rdiv_row.sv
// One (N+1)-bit trial-subtract/restore row: a ripple chain of rdiv_cell
// instances. Purely combinational.
module rdiv_row #(
  parameter int N = 8
) (
  input  logic [N:0] a,
  input  logic [N:0] b,
  input  logic       s,
  input  logic       s1,
  output logic [N:0] op,
  output logic       cout
);

  logic [N+1:0] carry;

  // Carry-in follows s so that subtraction forms a + ~b + 1.
  assign carry[0] = s;

  for (genvar i = 0; i <= N; i++) begin : g_cell
    rdiv_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .s    (s),
      .s1   (s1),
      .cin  (carry[i]),
      .op   (op[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[N+1];

endmodule

// File: rtl/restoring_div_ctrl.sv
// Sequential unsigned restoring divider controller: one quotient bit per clock
// through a single rdiv_row, with start/done handshake and divide-by-zero result.
module restoring_div_ctrl
  import rdiv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  rdiv_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [N:0] row_a;
  logic [N:0] row_op;
  logic       row_cout;
  logic       unused_r_msb;

  // R < D holds after every step, so the partial remainder MSB never feeds back.
  assign row_a        = {r_q[N-1:0], q_q[N-1]};
  assign unused_r_msb = r_q[N];

  // Restore whenever the trial subtraction borrows (carry-out low).
  rdiv_row #(.N(N)) u_row (
    .a    (row_a),
    .b    ({1'b0, d_q}),
    .s    (1'b1),
    .s1   (~row_cout),
    .op   (row_op),
    .cout (row_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          r_d   = '0;
          q_d   = dividend;
          d_d   = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        r_d   = row_op;
        q_d   = {q_q[N-2:0], row_cout};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          quot_d  = {q_q[N-2:0], row_cout};
          rem_d   = row_op[N-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
